// File: rtl/control_fsm_if.sv
// Handshake bundle between the multicycle RV32I controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath that obeys it.
interface control_fsm_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       is_imm;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, is_imm, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, is_imm, illegal
    );
endinterface

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the alu_op/is_imm pair.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_FETCH    | read instruction at PC, PC+4 on the live ALU result
// S_DECODE   | latch branch/JAL target (old PC + imm) into ALU-out
// S_MEMADR   | rs1 + imm address for load/store
// S_MEMREAD  | load request at ALU-out address
// S_MEMWB    | write loaded data to register file
// S_MEMWRITE | store request at ALU-out address
// S_EXECR    | R-type ALU operation
// S_EXECI    | I-type ALU operation
// S_ALUWB    | write ALU-out to register file
// S_BRANCH   | compare rs1/rs2, conditional PC write
// S_JAL      | PC <= ALU-out target, ALU computes old PC + 4 link
// S_JALR     | rs1 + imm target into ALU-out
// S_LUI      | zero + imm
// S_AUIPC    | old PC + imm
module control_fsm (
    input  logic          clk,
    input  logic          rst_n,
    control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
    } state_t;

    state_t     state_q, state_d;
    logic       op_legal;

    logic       mem_req_q,   mem_req_d;
    logic       mem_write_q, mem_write_d;
    logic       adr_src_q,   adr_src_d;
    logic       fetch_q,     fetch_d;
    logic       jal_q,       jal_d;
    logic       branch_q,    branch_d;
    logic       reg_write_q, reg_write_d;
    logic       decode_q,    decode_d;
    logic       is_imm_q,    is_imm_d;
    logic [1:0] alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] result_src_q, result_src_d;
    logic [1:0] alu_op_q,    alu_op_d;

    always_comb begin
        op_legal = 1'b1;
        state_d  = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_AUIPC;
                    default: begin
                        state_d  = S_FETCH;
                        op_legal = 1'b0;
                    end
                endcase
            end
            S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs are computed for the state about to be entered and registered,
    // so every output is glitch-free and the async reset clears them with the state.
    always_comb begin
        mem_req_d    = 1'b0;
        mem_write_d  = 1'b0;
        adr_src_d    = 1'b0;
        fetch_d      = 1'b0;
        jal_d        = 1'b0;
        branch_d     = 1'b0;
        reg_write_d  = 1'b0;
        decode_d     = 1'b0;
        is_imm_d     = 1'b0;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        result_src_d = 2'b00;
        alu_op_d     = 2'b00;
        case (state_d)
            S_FETCH: begin
                mem_req_d    = 1'b1;
                fetch_d      = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
            end
            S_DECODE: begin
                decode_d    = 1'b1;
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
            end
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
                adr_src_d   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                alu_op_d    = 2'b11;
                is_imm_d    = 1'b1;
            end
            S_ALUWB:  reg_write_d = 1'b1;
            S_BRANCH: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b01;
                branch_d    = 1'b1;
            end
            S_JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                jal_d       = 1'b1;
            end
            S_JALR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            S_LUI: begin
                alu_src_a_d = 2'b11;
                alu_src_b_d = 2'b01;
            end
            S_AUIPC: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            mem_req_q    <= 1'b1;
            mem_write_q  <= 1'b0;
            adr_src_q    <= 1'b0;
            fetch_q      <= 1'b1;
            jal_q        <= 1'b0;
            branch_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            decode_q     <= 1'b0;
            is_imm_q     <= 1'b0;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b10;
            result_src_q <= 2'b10;
            alu_op_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            adr_src_q    <= adr_src_d;
            fetch_q      <= fetch_d;
            jal_q        <= jal_d;
            branch_q     <= branch_d;
            reg_write_q  <= reg_write_d;
            decode_q     <= decode_d;
            is_imm_q     <= is_imm_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            result_src_q <= result_src_d;
            alu_op_q     <= alu_op_d;
        end
    end

    // Fetch strobes follow mem_ready within the cycle so a stall never loads IR or PC.
    assign bus.ir_write   = fetch_q & bus.mem_ready;
    assign bus.pc_update  = (fetch_q & bus.mem_ready) | jal_q;
    assign bus.illegal    = decode_q & ~op_legal;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.adr_src    = adr_src_q;
    assign bus.branch     = branch_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.alu_src_a  = alu_src_a_q;
    assign bus.alu_src_b  = alu_src_b_q;
    assign bus.result_src = result_src_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.is_imm     = is_imm_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized scoreboard bench for control_fsm: a step-level instruction model
// queues expected per-cycle outputs, a negedge monitor pops and compares.
module tb_control_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_fsm_if bus ();
    control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam int K_F = 0, K_D = 1, K_MA = 2, K_MR = 3, K_MWB = 4, K_MW = 5, K_XR = 6,
                   K_XI = 7, K_AWB = 8, K_BR = 9, K_JL = 10, K_JR = 11, K_LU = 12, K_AU = 13;

    typedef struct { logic [16:0] v; int k; } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int cyc_no = 0;

    function automatic logic [16:0] packed_out();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_update,
                bus.branch, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src,
                bus.alu_op, bus.is_imm, bus.illegal};
    endfunction

    // Expected outputs of one step, straight from the per-state output list.
    function automatic logic [16:0] step_out(int k, logic mr, logic bad);
        logic mreq, mw, adr, irw, pcu, br, rw, imm, ill;
        logic [1:0] sa, sbs, rs, aop;
        {mreq, mw, adr, irw, pcu, br, rw, imm, ill} = '0;
        sa = 2'b00; sbs = 2'b00; rs = 2'b00; aop = 2'b00;
        case (k)
            K_F:   begin mreq = 1; irw = mr; pcu = mr; sbs = 2'b10; rs = 2'b10; end
            K_D:   begin sa = 2'b01; sbs = 2'b01; ill = bad; end
            K_MA:  begin sa = 2'b10; sbs = 2'b01; end
            K_MR:  begin mreq = 1; adr = 1; end
            K_MWB: begin rs = 2'b01; rw = 1; end
            K_MW:  begin mreq = 1; mw = 1; adr = 1; end
            K_XR:  begin sa = 2'b10; sbs = 2'b00; aop = 2'b10; end
            K_XI:  begin sa = 2'b10; sbs = 2'b01; aop = 2'b11; imm = 1; end
            K_AWB: begin rs = 2'b00; rw = 1; end
            K_BR:  begin sa = 2'b10; sbs = 2'b00; aop = 2'b01; br = 1; end
            K_JL:  begin sa = 2'b01; sbs = 2'b10; pcu = 1; end
            K_JR:  begin sa = 2'b10; sbs = 2'b01; end
            K_LU:  begin sa = 2'b11; sbs = 2'b01; end
            K_AU:  begin sa = 2'b01; sbs = 2'b01; end
            default: ;
        endcase
        return {mreq, mw, adr, irw, pcu, br, rw, sa, sbs, rs, aop, imm, ill};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b exp=%b", name, got, exp);
        end
    endtask

    // Runs one whole instruction from its FETCH cycle; called at posedge+1.
    task automatic run_instr(input logic [6:0] op, input int stall_f, input int stall_m);
        int ks[$];
        logic bad;
        bad = 1'b0;
        ks.push_back(K_F);
        ks.push_back(K_D);
        case (op)
            7'b0000011: begin ks.push_back(K_MA); ks.push_back(K_MR); ks.push_back(K_MWB); end
            7'b0100011: begin ks.push_back(K_MA); ks.push_back(K_MW); end
            7'b0110011: begin ks.push_back(K_XR); ks.push_back(K_AWB); end
            7'b0010011: begin ks.push_back(K_XI); ks.push_back(K_AWB); end
            7'b1100011: ks.push_back(K_BR);
            7'b1101111: begin ks.push_back(K_JL); ks.push_back(K_AWB); end
            7'b1100111: begin ks.push_back(K_JR); ks.push_back(K_JL); ks.push_back(K_AWB); end
            7'b0110111: begin ks.push_back(K_LU); ks.push_back(K_AWB); end
            7'b0010111: begin ks.push_back(K_AU); ks.push_back(K_AWB); end
            default:    bad = 1'b1;
        endcase
        foreach (ks[i]) begin
            int st;
            st = (ks[i] == K_F) ? stall_f : ((ks[i] == K_MR || ks[i] == K_MW) ? stall_m : 0);
            for (int s = 0; s <= st; s++) begin
                exp_t e;
                bus.opcode    = op;
                bus.mem_ready = (s == st);
                e.v = step_out(ks[i], (s == st), bad);
                e.k = ks[i];
                sb_q.push_back(e);
                @(posedge clk);
                #1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cyc_no++;
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_underflow: got=empty exp=entry at cycle %0d", cyc_no);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("outputs cycle=%0d step=%0d", cyc_no, e.k), packed_out(), e.v);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [6:0] legal_ops [9];
    initial begin
        legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
        legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;
        legal_ops[6] = 7'b1100111; legal_ops[7] = 7'b0110111; legal_ops[8] = 7'b0010111;
    end

    initial begin
        bus.opcode    = 7'b0000000;
        bus.mem_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("reset_outputs", packed_out(), 17'b1_0_0_1_1_0_0_00_10_10_00_0_0);
        bus.mem_ready = 1'b0;
        #1;
        check("reset_outputs_stall", packed_out(), 17'b1_0_0_0_0_0_0_00_10_10_00_0_0);
        bus.mem_ready = 1'b1;
        rst_n = 1'b1;

        // Directed walk through the named scenarios, then randomized traffic.
        mon_en = 1'b1;
        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 3);
        run_instr(7'b0010011, 0, 0);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b1100111, 0, 0);
        run_instr(7'b1111111, 0, 0);
        run_instr(7'b0100011, 2, 2);
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 8)];
            else                          op = 7'($urandom_range(0, 127));
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        mon_en = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got=%0d left exp=0", sb_q.size());
        end

        // Reset in the middle of a stalled store.
        bus.opcode    = 7'b0100011;
        bus.mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.mem_ready = 1'b0;
        #1;
        check1("memwrite_before_reset", bus.mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("memwrite_drops_on_reset", bus.mem_write, 1'b0);
        check("outputs_in_reset", packed_out(), 17'b1_0_0_0_0_0_0_00_10_10_00_0_0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("fetch_after_release", packed_out(), 17'b1_0_0_0_0_0_0_00_10_10_00_0_0);
        bus.mem_ready = 1'b1;
        #1;
        check1("fetch_irwrite_after_release", bus.ir_write, 1'b1);
        @(posedge clk); #1;
        check("decode_after_release", packed_out(), 17'b0_0_0_0_0_0_0_01_01_00_00_0_0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
